// File: rtl/alu_pkg.sv
// Shared ALU datapath types and default sizing constants.
package alu_pkg;

  localparam int ALU_OPERANDSIZE = 64;
  localparam int ALU_REGADDR     = 5;
  localparam int ALU_WB_DEPTH    = 4;

  typedef struct packed {
    logic [ALU_REGADDR-1:0]     rd;
    logic [ALU_OPERANDSIZE-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Generic synchronous in-order FIFO with registered occupancy count.
// Storage is not cleared on reset; resetting pointers and count flushes it.
module wb_fifo import alu_pkg::*; #(
  parameter int W     = $bits(wb_entry_t),
  parameter int DEPTH = ALU_WB_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_wb_buffer.sv
// ALU result write-back buffer: valid/ready intake, r0 filter, FIFO drain to the
// register-file write port. Optional same-cycle bypass when ALU_WB_BYPASS_EN is defined.
module alu_wb_buffer import alu_pkg::*; #(
  parameter int OPERANDSIZE = ALU_OPERANDSIZE,
  parameter int DEPTH       = ALU_WB_DEPTH,
  parameter int REGADDR     = ALU_REGADDR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [REGADDR-1:0]         res_rd,
  input  logic [OPERANDSIZE-1:0]     res_data,
  output logic                       wr_en,
  input  logic                       wr_ready,
  output logic [REGADDR-1:0]         wr_addr,
  output logic [OPERANDSIZE-1:0]     wr_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       drop_zero
);

  localparam int EW = REGADDR + OPERANDSIZE;
  localparam int CW = $clog2(DEPTH+1);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high
  // at the rising edge; ready never depends on valid in the same cycle.

  logic [EW-1:0] head;
  logic          accept;
  logic          nonzero;
  logic          bypass;
  logic          push;
  logic          pop;
  logic          has_data;

  assign has_data  = (count != '0);
  assign res_ready = (count != CW'(DEPTH));
  assign accept    = res_valid && res_ready;
  assign nonzero   = (res_rd != '0);

`ifdef ALU_WB_BYPASS_EN
  assign bypass = !has_data && res_valid && nonzero && wr_ready;
  assign wr_en  = has_data || (!has_data && res_valid && nonzero);
`else
  assign bypass = 1'b0;
  assign wr_en  = has_data;
`endif

  assign push = accept && nonzero && !bypass;
  assign pop  = has_data && wr_ready;

  wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({res_rd, res_data}),
    .pop   (pop),
    .dout  (head),
    .count (count)
  );

  // Outputs read as zero when nothing is offered so reset/idle values are clean.
  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    if (has_data) begin
      {wr_addr, wr_data} = head;
    end
`ifdef ALU_WB_BYPASS_EN
    else if (res_valid && nonzero) begin
      wr_addr = res_rd;
      wr_data = res_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_zero <= 1'b0;
    else     drop_zero <= accept && !nonzero;
  end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Self-checking bench for alu_wb_buffer; scoreboard of accepted results vs. writes.
`timescale 1ns/1ps
module tb_alu_wb_buffer;
  import alu_pkg::*;

  localparam int OS = 64;
  localparam int RA = 5;
  localparam int DP = 4;
  localparam int CW = $clog2(DP+1);
  localparam int EW = RA + OS;

  logic          clk = 1'b0;
  logic          rst;
  logic          res_valid;
  logic          res_ready;
  logic [RA-1:0] res_rd;
  logic [OS-1:0] res_data;
  logic          wr_en;
  logic          wr_ready;
  logic [RA-1:0] wr_addr;
  logic [OS-1:0] wr_data;
  logic [CW-1:0] count;
  logic          drop_zero;

  int tests_run = 0;
  int tests_failed = 0;
  logic [EW-1:0] exp_q[$];
  logic          sb_enable = 1'b1;

  alu_wb_buffer #(.OPERANDSIZE(OS), .DEPTH(DP), .REGADDR(RA)) dut (
    .clk       (clk),
    .rst       (rst),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_rd    (res_rd),
    .res_data  (res_data),
    .wr_en     (wr_en),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .count     (count),
    .drop_zero (drop_zero)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Inputs change 1ns after posedge, so the negedge sees what the next edge will transfer.
  always @(negedge clk) begin
    if (!rst && sb_enable) begin
      if (res_valid && res_ready && res_rd != '0) exp_q.push_back({res_rd, res_data});
      if (wr_en && wr_ready) begin
        logic [EW-1:0] exp_e;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected_write: got addr=%0d data=%h, required no write", wr_addr, wr_data);
        end else begin
          exp_e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== exp_e) begin
            tests_failed++;
            $display("FAIL sb_write: got addr=%0d data=%h, required addr=%0d data=%h",
                     wr_addr, wr_data, exp_e[EW-1:OS], exp_e[OS-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [RA-1:0] rd, input logic [OS-1:0] d);
    res_valid = v;
    res_rd    = rd;
    res_data  = d;
  endtask

  task automatic drain(input string name);
    int n = 0;
    wr_ready = 1'b1;
    drive(1'b0, '0, '0);
    while (count != '0 && n < 40) begin
      step();
      n++;
    end
    tests_run++;
    if (count !== '0) begin
      tests_failed++;
      $display("FAIL %s_drain_timeout: got count=%0d, required 0", name, count);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    wr_ready = 1'b0;
    drive(1'b0, '0, '0);
    step();
    step();
    rst = 1'b0;
    step();
    tests_run++;
    if (res_ready !== 1'b1 || wr_en !== 1'b0 || count !== '0 || drop_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: got ready=%b wr_en=%b count=%0d drop=%b, required 1 0 0 0",
               res_ready, wr_en, count, drop_zero);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, RA'(i + 10), OS'(64'h100 + i));
      step();
    end
    drive(1'b0, '0, '0);
    tests_run++;
    if (count !== CW'(3)) begin
      tests_failed++;
      $display("FAIL reset_fill: got count=%0d, required 3", count);
    end
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (wr_en !== 1'b0 || count !== '0 || wr_addr !== '0 || wr_data !== '0 || res_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_async: got wr_en=%b count=%0d addr=%0d data=%h ready=%b, required 0 0 0 0 1",
               wr_en, count, wr_addr, wr_data, res_ready);
    end
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    tests_run++;
    if (res_ready !== 1'b1 || wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: got ready=%b wr_en=%b, required 1 0", res_ready, wr_en);
    end
  endtask

  task automatic test_in_order();
    wr_ready = 1'b1;
    drive(1'b1, 5'd3, 64'hA5A5);
`ifndef ALU_WB_BYPASS_EN
    tests_run++;
    if (wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL order_no_bypass: got wr_en=%b, required 0", wr_en);
    end
`endif
    step();
    drive(1'b1, 5'd4, 64'h5A5A);
`ifndef ALU_WB_BYPASS_EN
    tests_run++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 64'hA5A5) begin
      tests_failed++;
      $display("FAIL order_first: got en=%b addr=%0d data=%h, required 1 3 a5a5", wr_en, wr_addr, wr_data);
    end
`endif
    step();
    drive(1'b0, '0, '0);
`ifndef ALU_WB_BYPASS_EN
    tests_run++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd4 || wr_data !== 64'h5A5A) begin
      tests_failed++;
      $display("FAIL order_second: got en=%b addr=%0d data=%h, required 1 4 5a5a", wr_en, wr_addr, wr_data);
    end
`endif
    drain("order");
  endtask

  task automatic test_backpressure();
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, RA'(i + 1), {$urandom, $urandom});
      @(negedge clk);
      tests_run++;
      if (res_ready !== (i < 4)) begin
        tests_failed++;
        $display("FAIL bp_ready_%0d: got %b, required %b", i, res_ready, (i < 4));
      end
      if (i < 4) step();
    end
    tests_run++;
    if (count !== CW'(4)) begin
      tests_failed++;
      $display("FAIL bp_full_count: got %0d, required 4", count);
    end
    step();
    wr_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (res_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_full_pop_refuse: got ready=%b, required 0", res_ready);
    end
    step();
    tests_run++;
    if (count !== CW'(3) || res_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_after_pop: got count=%0d ready=%b, required 3 1", count, res_ready);
    end
    step();
    drive(1'b0, '0, '0);
    tests_run++;
    if (count !== CW'(3)) begin
      tests_failed++;
      $display("FAIL bp_fifth_taken: got count=%0d, required 3", count);
    end
    drain("bp");
  endtask

  task automatic test_drop_zero();
    wr_ready = 1'b1;
    drive(1'b1, 5'd0, 64'hFFFF);
    @(negedge clk);
    tests_run++;
    if (res_ready !== 1'b1 || wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_accept: got ready=%b wr_en=%b, required 1 0", res_ready, wr_en);
    end
    step();
    drive(1'b0, '0, '0);
    tests_run++;
    if (drop_zero !== 1'b1 || count !== '0 || wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_pulse: got drop=%b count=%0d wr_en=%b, required 1 0 0", drop_zero, count, wr_en);
    end
    step();
    tests_run++;
    if (drop_zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_one_cycle: got drop=%b, required 0", drop_zero);
    end
  endtask

  task automatic test_back_to_back();
    wr_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, RA'(20 + i), {$urandom, $urandom});
      step();
    end
    wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, RA'(1 + (i % 31)), {$urandom, $urandom});
      @(negedge clk);
      tests_run++;
      if (count !== CW'(2)) begin
        tests_failed++;
        $display("FAIL b2b_count_%0d: got %0d, required 2", i, count);
      end
      step();
    end
    drain("b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      wr_ready = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 1) == 1), RA'($urandom_range(0, 31)), {$urandom, $urandom});
      step();
    end
    drain("rand");
  endtask

`ifdef ALU_WB_BYPASS_EN
  task automatic test_bypass();
    wr_ready = 1'b1;
    drive(1'b1, 5'd7, 64'h1234);
    #1;
    tests_run++;
    if (wr_en !== 1'b1 || wr_addr !== 5'd7 || wr_data !== 64'h1234 || count !== '0) begin
      tests_failed++;
      $display("FAIL bypass_same_cycle: got en=%b addr=%0d data=%h count=%0d, required 1 7 1234 0",
               wr_en, wr_addr, wr_data, count);
    end
    step();
    drive(1'b0, '0, '0);
    tests_run++;
    if (count !== '0 || wr_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL bypass_not_stored: got count=%0d wr_en=%b, required 0 0", count, wr_en);
    end
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_in_order();
    test_backpressure();
    test_drop_zero();
    test_back_to_back();
`ifdef ALU_WB_BYPASS_EN
    test_bypass();
`endif
    test_random();
    step();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
